multiplicador_segmentado: RTL and testbench

//  Pipelined signed multiply-accumulate that rebuilds a dividend from divider results: Num = Coc*Den + Res.

---
 rtl/multiplicador_segmentado.sv | 152 +++++++++++++++
 tb/tb_multiplicador_segmentado.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_segmentado.sv
// rtl/multiplicador_segmentado.sv - pipelined signed multiply-accumulate Num = Coc*Den + Res
//
// Purpose:
//   Rebuilds a dividend from pipelined-divider results. The multiplier uses
//   one radix-2 shift-add stage per quotient bit on operand magnitudes, then
//   applies the product sign and adds the remainder.
//   Throughput is one op per cycle. Latency is fixed at tamanyo+2 register
//   stages. There is no back-pressure.
//
// Parameter:
//   tamanyo : operand/result width in bits, two's complement (>= 4)
//
// Ports:
//   CLK   in   clock, rising edge
//   RSTa  in   asynchronous reset, active-low
//   Start in   launch an op on the current Coc/Den/Res
//   Coc   in   signed multiplier (quotient)
//   Den   in   signed multiplicand (divisor)
//   Res   in   signed addend (remainder)
//   Done  out  one-cycle pulse per completed op
//   Num   out  low tamanyo bits of Coc*Den+Res
//   Ovf   out  result does not fit in signed tamanyo bits
//              (port exists only when OVERFLOW_DETECT_EN is defined)
//
// Configuration macro: OVERFLOW_DETECT_EN

module multiplicador_segmentado #(
  parameter int tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic [tamanyo-1:0] Coc,
  input  logic [tamanyo-1:0] Den,
  input  logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic [tamanyo-1:0] Num
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic               Ovf
`endif
);

  localparam int W = 2 * tamanyo;

  // Magnitudes are only consumed by stages 1..tamanyo.
  // As a result, the copies after the last stage are never kept.
  logic [tamanyo-1:0] r_magc [0:tamanyo-1];
  logic [tamanyo-1:0] r_magd [0:tamanyo-1];
  logic               r_sgn  [0:tamanyo];
  logic [tamanyo-1:0] r_res  [0:tamanyo];
  logic [W-1:0]       r_p    [0:tamanyo];
  logic               r_vld  [0:tamanyo];

  logic               r_done;
  logic [tamanyo-1:0] r_num;

  logic [tamanyo-1:0] w_magc;
  logic [tamanyo-1:0] w_magd;
  logic [W-1:0]       w_pp [1:tamanyo];
  logic [tamanyo-1:0] w_num;

  // The most-negative input negates to itself.
  // Read as unsigned, that value is 2^(tamanyo-1), which is the correct magnitude.
  assign w_magc = Coc[tamanyo-1] ? (~Coc + 1'b1) : Coc;
  assign w_magd = Den[tamanyo-1] ? (~Den + 1'b1) : Den;

  // Stage k adds MagD<<(k-1) when quotient bit k-1 is set.
  always_comb begin
    for (int k = 1; k <= tamanyo; k++) begin
      w_pp[k] = '0;
      if (r_magc[k-1][k-1])
        w_pp[k] = {{tamanyo{1'b0}}, r_magd[k-1]} << (k - 1);
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic [W:0] w_pmag;
  logic [W:0] w_full;
  logic       w_ovf;
  logic       r_ovf;

  always_comb begin
    w_pmag = {1'b0, r_p[tamanyo]};
    w_full = (r_sgn[tamanyo] ? (~w_pmag + 1'b1) : w_pmag)
           + {{(tamanyo + 1){r_res[tamanyo][tamanyo-1]}}, r_res[tamanyo]};
    w_num  = w_full[tamanyo-1:0];
    // Fits iff every bit above the result MSB repeats the result MSB.
    w_ovf  = (w_full[W:tamanyo] != {(tamanyo + 1){w_full[tamanyo-1]}});
  end
`else
  logic [tamanyo-1:0] w_plo;

  // Only the low bits are kept, so negation and addition are done at result width.
  always_comb begin
    w_plo = r_p[tamanyo][tamanyo-1:0];
    w_num = (r_sgn[tamanyo] ? (~w_plo + 1'b1) : w_plo) + r_res[tamanyo];
  end
`endif

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int k = 0; k < tamanyo; k++) begin
        r_magc[k] <= '0;
        r_magd[k] <= '0;
      end
      for (int k = 0; k <= tamanyo; k++) begin
        r_sgn[k] <= 1'b0;
        r_res[k] <= '0;
        r_p[k]   <= '0;
        r_vld[k] <= 1'b0;
      end
      r_done <= 1'b0;
      r_num  <= '0;
    end else begin
      r_vld[0]  <= Start;
      r_magc[0] <= w_magc;
      r_magd[0] <= w_magd;
      r_sgn[0]  <= Coc[tamanyo-1] ^ Den[tamanyo-1];
      r_res[0]  <= Res;
      r_p[0]    <= '0;
      for (int k = 1; k <= tamanyo; k++) begin
        r_p[k]   <= r_p[k-1] + w_pp[k];
        r_sgn[k] <= r_sgn[k-1];
        r_res[k] <= r_res[k-1];
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 1; k < tamanyo; k++) begin
        r_magc[k] <= r_magc[k-1];
        r_magd[k] <= r_magd[k-1];
      end
      r_done <= r_vld[tamanyo];
      if (r_vld[tamanyo])
        r_num <= w_num;
    end
  end

`ifdef OVERFLOW_DETECT_EN
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa)
      r_ovf <= 1'b0;
    else if (r_vld[tamanyo])
      r_ovf <= w_ovf;
  end

  assign Ovf = r_ovf;
`endif

  assign Done = r_done;
  assign Num  = r_num;

endmodule

// File: tb/tb_multiplicador_segmentado.sv
// tb/tb_multiplicador_segmentado.sv - scoreboard bench for multiplicador_segmentado

module tb_multiplicador_segmentado;

  localparam int T   = 32;
  localparam int LAT = T + 2;

  logic         CLK;
  logic         RSTa;
  logic         Start;
  logic [T-1:0] Coc;
  logic [T-1:0] Den;
  logic [T-1:0] Res;
  logic         Done;
  logic [T-1:0] Num;
`ifdef OVERFLOW_DETECT_EN
  logic         Ovf;
`endif

  multiplicador_segmentado #(.tamanyo(T)) dut (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .Start (Start),
    .Coc   (Coc),
    .Den   (Den),
    .Res   (Res),
    .Done  (Done),
    .Num   (Num)
`ifdef OVERFLOW_DETECT_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  typedef struct {
    logic [T-1:0] num;
    logic         ovf;
    int           launch;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  logic [T-1:0] last_num = '0;
  logic         last_ovf = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // Output side of the scoreboard.
  // Every Done pops one entry, and every idle cycle must hold the last result.
  always @(negedge CLK) begin
    exp_t e;
    if (RSTa === 1'b1) begin
      if (Done === 1'b1) begin
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_done: got Done=1 with empty scoreboard, want Done=0");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_cmp++;
          assert (Num === e.num) else begin
            n_err++;
            $error("FAIL num: got %h want %h", Num, e.num);
          end
          n_cmp++;
          assert ((cyc - e.launch) == LAT) else begin
            n_err++;
            $error("FAIL latency: got %0d want %0d", cyc - e.launch, LAT);
          end
`ifdef OVERFLOW_DETECT_EN
          n_cmp++;
          assert (Ovf === e.ovf) else begin
            n_err++;
            $error("FAIL ovf: got %b want %b", Ovf, e.ovf);
          end
`endif
          last_num = e.num;
          last_ovf = e.ovf;
        end
      end else begin
        n_cmp++;
        assert (Done === 1'b0 && Num === last_num) else begin
          n_err++;
          $error("FAIL hold: got Done=%b Num=%h want Done=0 Num=%h", Done, Num, last_num);
        end
`ifdef OVERFLOW_DETECT_EN
        n_cmp++;
        assert (Ovf === last_ovf) else begin
          n_err++;
          $error("FAIL ovf_hold: got %b want %b", Ovf, last_ovf);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one op for one cycle and push its expected result.
  task automatic op(input logic [T-1:0] c, input logic [T-1:0] d, input logic [T-1:0] r);
    exp_t   e;
    longint full;
    full     = longint'($signed(c)) * longint'($signed(d)) + longint'($signed(r));
    e.num    = full[T-1:0];
    e.ovf    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    e.launch = cyc;
    sb.push_back(e);
    Coc   = c;
    Den   = d;
    Res   = r;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    RSTa  = 1'b0;
    Start = 1'b0;
    Coc   = '0;
    Den   = '0;
    Res   = '0;
    tick();
    tick();
    n_cmp++;
    assert (Done === 1'b0 && Num === '0) else begin
      n_err++;
      $error("FAIL reset_state: got Done=%b Num=%h want 0/0", Done, Num);
    end
`ifdef OVERFLOW_DETECT_EN
    n_cmp++;
    assert (Ovf === 1'b0) else begin
      n_err++;
      $error("FAIL reset_ovf: got %b want 0", Ovf);
    end
`endif
    RSTa = 1'b1;
    tick();

    op(32'd7, 32'd3, 32'd2);
    drain();
    op(-32'sd7, 32'd3, -32'sd2);
    op(-32'sd7, -32'sd3, 32'd0);
    drain();

    op(32'd10, 32'd10, 32'd0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    op(32'd0, 32'd5, 32'd4);
    op(32'd1, 32'h8000_0000, 32'd0);
    drain();

    op(32'h8000_0000, 32'h8000_0000, 32'd0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    op(32'd0, 32'd12345, -32'sd9);
    op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drain();

    op(32'h0001_0000, 32'h0001_0000, 32'd5);
    op(32'd2, 32'd3, 32'd0);
    drain();

    for (int i = 0; i < 24; i++)
      op($urandom, $urandom, $urandom);
    drain();

    // Inputs toggle without Start; the monitor checks that nothing moves.
    for (int i = 0; i < 100; i++) begin
      Coc = $urandom;
      Den = $urandom;
      Res = $urandom;
      tick();
    end

    // Reset arrives while an op is in flight; that op must never appear.
    op(32'd9, 32'd9, 32'd9);
    repeat (9) tick();
    RSTa = 1'b0;
    sb.delete();
    last_num = '0;
    last_ovf = 1'b0;
    tick();
    tick();
    n_cmp++;
    assert (Done === 1'b0 && Num === '0) else begin
      n_err++;
      $error("FAIL midreset_state: got Done=%b Num=%h want 0/0", Done, Num);
    end
    RSTa = 1'b1;
    repeat (LAT + 10) tick();
    op(32'd6, -32'sd4, 32'd1);
    drain();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
